ysyx_22050710_wbu_pipe: RTL and testbench
=========================================

// Module: ysyx_22050710_wbu_pipe
// PURPOSE
//  Registered write-back stage: successor of the combinational WB unit. Holds one MEM->WB instruction
//  under a valid/allowin handshake, drives the GPR/CSR write bus to the register files, publishes a
//  forwarding bus for ID, and maintains the retired-instruction counter (minstret source).
//  Sits between the MEM stage and the GPR/CSR register files; accepts backpressure from a busy RF port.
// PARAMETERS
//  GPR_ADDR_WD      5    GPR index width
//  GPR_WD           64   GPR data width
//  CSR_ADDR_WD      12   CSR index width
//  CSR_WD           64   CSR data width
//  PC_WD            64   PC width
//  CNT_WD           64   retire counter width
//  WS_TO_RF_BUS_WD  2+GPR_ADDR_WD+GPR_WD+CSR_ADDR_WD+CSR_WD (=147)
//  MS_TO_WS_BUS_WD  WS_TO_RF_BUS_WD+PC_WD (=211)
// PORTS
//  i_clk            in   1                clock
//  i_rst_n          in   1                synchronous reset, active low
//  i_ms_to_ws_valid in   1                MEM holds a valid instruction
//  i_ms_to_ws_bus   in   MS_TO_WS_BUS_WD  {gpr_wen,gpr_waddr,gpr_wdata,csr_wen,csr_waddr,csr_wdata,pc}
//  o_ws_allowin     out  1                WB can accept this cycle
//  i_rf_busy        in   1                RF write port unavailable; WB must hold
//  i_flush          in   1                kill WB contents, accept nothing this cycle
//  o_to_rf_bus      out  WS_TO_RF_BUS_WD  {gpr_wen,gpr_waddr,gpr_wdata,csr_wen,csr_waddr,csr_wdata}
//  o_ws_fwd_bus     out  1+GPR_ADDR_WD+GPR_WD {fwd_valid,waddr,wdata} bypass to ID
//  o_retire_valid   out  1                instruction retires this cycle
//  o_retire_pc      out  PC_WD            pc of retiring instruction
//  i_cnt_wen        in   1                software write of retire counter
//  i_cnt_wdata      in   CNT_WD           value for software write
//  o_retire_cnt     out  CNT_WD           retire counter
// BEHAVIOUR
//  - Reset (i_rst_n=0 at posedge): ws_valid=0, bus register=0, counter=0. All bus outputs 0 after reset.
//  - ready_go = ~i_rf_busy; o_ws_allowin = ~ws_valid | ready_go (combinational, no flush term).
//  - Capture: at posedge, if i_flush -> ws_valid<=0; else if o_ws_allowin -> ws_valid<=i_ms_to_ws_valid,
//    bus register loads i_ms_to_ws_bus only when i_ms_to_ws_valid&o_ws_allowin (else holds).
//  - Latency: bus accepted in cycle N appears on o_to_rf_bus in cycle N+1; back-to-back throughput 1/cycle.
//  - Stall: while i_rf_busy & ws_valid, register and outputs hold; o_retire_valid=0; RF wen outputs 0.
//  - commit = ws_valid & ready_go & ~i_flush. o_to_rf_bus = {WD{commit}} & stored fields.
//  - GPR x0: gpr_wen forced 0 on o_to_rf_bus and fwd_valid forced 0 when gpr_waddr==0.
//  - o_ws_fwd_bus: fwd_valid = ws_valid & gpr_wen & (waddr!=0), independent of i_rf_busy (data is final).
//  - o_retire_valid = commit; o_retire_pc = stored pc (0 when ~ws_valid).
//  - Counter: if i_cnt_wen -> cnt<=i_cnt_wdata (retire in same cycle is NOT added); else if commit
//    -> cnt<=cnt+1, wraps modulo 2^CNT_WD. o_retire_cnt is the register value.
//  - Flush same cycle as valid WB and i_flush: no commit, no RF write, no count; WB empty next cycle.
//  - Reset mid-stall: reset dominates; held instruction dropped, no write issued.
// STRUCTURE
//  - Shared package/header: bus field offsets (GPR_WEN_POS, CSR_WEN_POS, PC_LSB...) and bus-width
//    localparams, reused by MEM stage and RF top.
//  - One sub-module: ysyx_22050710_retire_cnt (counter with write-priority, CNT_WD param).
//  - Stage register and output gating inline in this module.
// TESTING
//  1 Reset: hold i_rst_n=0 2 cycles with valid input -> allowin=1, all outputs 0, cnt=0.
//  2 Stream: 3 back-to-back valid insts (x5=0x11,x6=0x22,x7=0x33) -> RF writes in cycles N+1..N+3, cnt=3.
//  3 Backpressure: i_rf_busy=1 for 2 cycles with WB valid -> allowin=0, no wen, fwd_valid=1; write on release.
//  4 x0 write: gpr_wen=1,waddr=0 -> o_to_rf_bus gpr_wen=0, fwd_valid=0, retire_valid=1, cnt+1.
//  5 Counter: cnt=0xFFFF_FFFF_FFFF_FFFF + commit -> 0; i_cnt_wen=1,wdata=100 with commit -> cnt=100.
//  6 Flush: i_flush with WB valid and MEM valid -> no write, no retire, ws_valid=0 next cycle.

Source files
------------

// File: rtl/ysyx_22050710_wbu_pipe_pkg.sv
// ysyx_22050710_wbu_pipe_pkg: shared bus widths and field offsets for the MEM->WB->RF path
package ysyx_22050710_wbu_pipe_pkg;
  localparam int GPR_ADDR_WD     = 5;
  localparam int GPR_WD          = 64;
  localparam int CSR_ADDR_WD     = 12;
  localparam int CSR_WD          = 64;
  localparam int PC_WD           = 64;
  localparam int CNT_WD          = 64;
  localparam int WS_TO_RF_BUS_WD = 2 + GPR_ADDR_WD + GPR_WD + CSR_ADDR_WD + CSR_WD;
  localparam int MS_TO_WS_BUS_WD = WS_TO_RF_BUS_WD + PC_WD;
  localparam int WS_FWD_BUS_WD   = 1 + GPR_ADDR_WD + GPR_WD;
  localparam int PC_LSB          = 0;
  localparam int CSR_WDATA_LSB   = PC_LSB + PC_WD;
  localparam int CSR_WADDR_LSB   = CSR_WDATA_LSB + CSR_WD;
  localparam int CSR_WEN_POS     = CSR_WADDR_LSB + CSR_ADDR_WD;
  localparam int GPR_WDATA_LSB   = CSR_WEN_POS + 1;
  localparam int GPR_WADDR_LSB   = GPR_WDATA_LSB + GPR_WD;
  localparam int GPR_WEN_POS     = GPR_WADDR_LSB + GPR_ADDR_WD;
  typedef struct packed {
    logic                   gpr_wen;
    logic [GPR_ADDR_WD-1:0] gpr_waddr;
    logic [GPR_WD-1:0]      gpr_wdata;
    logic                   csr_wen;
    logic [CSR_ADDR_WD-1:0] csr_waddr;
    logic [CSR_WD-1:0]      csr_wdata;
    logic [PC_WD-1:0]       pc;
  } ms_to_ws_t;
endpackage

// File: rtl/ysyx_22050710_wbu_pipe_if.sv
// ysyx_22050710_wbu_pipe_if: MEM/RF/CSR-side signal bundle of the write-back stage
interface ysyx_22050710_wbu_pipe_if;
  import ysyx_22050710_wbu_pipe_pkg::*;
  logic                       i_ms_to_ws_valid;
  logic [MS_TO_WS_BUS_WD-1:0] i_ms_to_ws_bus;
  logic                       o_ws_allowin;
  logic                       i_rf_busy;
  logic                       i_flush;
  logic [WS_TO_RF_BUS_WD-1:0] o_to_rf_bus;
  logic [WS_FWD_BUS_WD-1:0]   o_ws_fwd_bus;
  logic                       o_retire_valid;
  logic [PC_WD-1:0]           o_retire_pc;
  logic                       i_cnt_wen;
  logic [CNT_WD-1:0]          i_cnt_wdata;
  logic [CNT_WD-1:0]          o_retire_cnt;
  modport master (
    output i_ms_to_ws_valid, i_ms_to_ws_bus, i_rf_busy, i_flush, i_cnt_wen, i_cnt_wdata,
    input  o_ws_allowin, o_to_rf_bus, o_ws_fwd_bus, o_retire_valid, o_retire_pc, o_retire_cnt
  );
  modport slave (
    input  i_ms_to_ws_valid, i_ms_to_ws_bus, i_rf_busy, i_flush, i_cnt_wen, i_cnt_wdata,
    output o_ws_allowin, o_to_rf_bus, o_ws_fwd_bus, o_retire_valid, o_retire_pc, o_retire_cnt
  );
endinterface

// File: rtl/ysyx_22050710_retire_cnt.sv
// ysyx_22050710_retire_cnt: retired-instruction counter, software write beats increment
module ysyx_22050710_retire_cnt #(
  parameter int CNT_WD = 64
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_wen,
  input  logic [CNT_WD-1:0] i_wdata,
  input  logic              i_inc,
  output logic [CNT_WD-1:0] o_cnt
);
  logic [CNT_WD-1:0] r_cnt;
  // write wins over a same-cycle retire; increment wraps naturally
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_cnt <= '0;
    else if (i_wen) r_cnt <= i_wdata;
    else if (i_inc) r_cnt <= r_cnt + CNT_WD'(1);
  end
  assign o_cnt = r_cnt;
endmodule

// File: rtl/ysyx_22050710_wbu_pipe.sv
// ysyx_22050710_wbu_pipe: registered write-back stage with RF write, ID bypass and retire count
module ysyx_22050710_wbu_pipe
  import ysyx_22050710_wbu_pipe_pkg::*;
(
  input logic                     i_clk,
  input logic                     i_rst_n,
  ysyx_22050710_wbu_pipe_if.slave io_ws
);
  logic                       r_valid;
  logic [MS_TO_WS_BUS_WD-1:0] r_bus;
  logic                       w_ready_go;
  logic                       w_allowin;
  logic                       w_commit;
  logic                       w_gpr_wen;
  logic [GPR_ADDR_WD-1:0]     w_gpr_waddr;
  logic [GPR_WD-1:0]          w_gpr_wdata;
  assign w_ready_go  = ~io_ws.i_rf_busy;
  assign w_allowin   = ~r_valid | w_ready_go;
  assign w_commit    = r_valid & w_ready_go & ~io_ws.i_flush;
  assign w_gpr_waddr = r_bus[GPR_WADDR_LSB +: GPR_ADDR_WD];
  assign w_gpr_wdata = r_bus[GPR_WDATA_LSB +: GPR_WD];
  assign w_gpr_wen   = r_bus[GPR_WEN_POS] & (w_gpr_waddr != '0);
  // stage register: flush empties the stage, payload loads only on an accepted instruction
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_valid <= 1'b0;
      r_bus   <= '0;
    end else if (io_ws.i_flush) begin
      r_valid <= 1'b0;
    end else if (w_allowin) begin
      r_valid <= io_ws.i_ms_to_ws_valid;
      if (io_ws.i_ms_to_ws_valid) r_bus <= io_ws.i_ms_to_ws_bus;
    end
  end
  assign io_ws.o_ws_allowin   = w_allowin;
  assign io_ws.o_to_rf_bus    = {WS_TO_RF_BUS_WD{w_commit}} &
                                {w_gpr_wen, w_gpr_waddr, w_gpr_wdata, r_bus[CSR_WEN_POS:CSR_WDATA_LSB]};
  assign io_ws.o_ws_fwd_bus   = {r_valid & w_gpr_wen, w_gpr_waddr, w_gpr_wdata};
  assign io_ws.o_retire_valid = w_commit;
  assign io_ws.o_retire_pc    = {PC_WD{r_valid}} & r_bus[PC_LSB +: PC_WD];
  ysyx_22050710_retire_cnt #(.CNT_WD(CNT_WD)) u_retire_cnt (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_wen   (io_ws.i_cnt_wen),
    .i_wdata (io_ws.i_cnt_wdata),
    .i_inc   (w_commit),
    .o_cnt   (io_ws.o_retire_cnt)
  );
endmodule

// File: tb/tb_ysyx_22050710_wbu_pipe.sv
// tb_ysyx_22050710_wbu_pipe: directed stimulus, queue-based reference model and literal checks
module tb_ysyx_22050710_wbu_pipe;
  import ysyx_22050710_wbu_pipe_pkg::*;
  logic clk = 1'b0;
  logic rst_n;
  int   n_vec = 0;
  int   n_err = 0;
  bit   mon_en = 1'b0;
  ysyx_22050710_wbu_pipe_if wif ();
  ysyx_22050710_wbu_pipe dut (.i_clk(clk), .i_rst_n(rst_n), .io_ws(wif.slave));
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic ms_to_ws_t mk(input logic gw, input logic [4:0] ga, input logic [63:0] gd,
                                   input logic cw, input logic [11:0] ca, input logic [63:0] cd,
                                   input logic [63:0] pc);
    ms_to_ws_t b;
    b = '{gw, ga, gd, cw, ca, cd, pc};
    return b;
  endfunction

  function automatic logic [WS_TO_RF_BUS_WD-1:0] rf_of(input ms_to_ws_t b);
    return {b.gpr_wen && b.gpr_waddr != 5'd0, b.gpr_waddr, b.gpr_wdata, b.csr_wen, b.csr_waddr, b.csr_wdata};
  endfunction

  ms_to_ws_t   slot[$];
  logic [63:0] m_cnt = '0;

  // reference: the stage holds at most one instruction; it leaves when the RF is free and no flush
  always @(negedge clk) if (mon_en) begin
    ms_to_ws_t h;
    bit has, al, ret;
    has = slot.size() != 0;
    h   = has ? slot[0] : '0;
    al  = !has || !wif.i_rf_busy;
    ret = has && !wif.i_rf_busy && !wif.i_flush;
    chk("m_allowin", wif.o_ws_allowin, al);
    chk("m_retire_valid", wif.o_retire_valid, ret);
    chk("m_to_rf_bus", wif.o_to_rf_bus, ret ? rf_of(h) : '0);
    chk("m_fwd_valid", wif.o_ws_fwd_bus[WS_FWD_BUS_WD-1], has && h.gpr_wen && h.gpr_waddr != 5'd0);
    if (wif.o_ws_fwd_bus[WS_FWD_BUS_WD-1])
      chk("m_fwd_payload", wif.o_ws_fwd_bus[WS_FWD_BUS_WD-2:0], {h.gpr_waddr, h.gpr_wdata});
    chk("m_retire_pc", wif.o_retire_pc, has ? h.pc : 64'h0);
    chk("m_retire_cnt", wif.o_retire_cnt, m_cnt);
    if (!rst_n) begin
      slot.delete();
      m_cnt = '0;
    end else begin
      m_cnt = wif.i_cnt_wen ? wif.i_cnt_wdata : m_cnt + (ret ? 64'd1 : 64'd0);
      if (wif.i_flush) slot.delete();
      else if (al) begin
        if (has) void'(slot.pop_front());
        if (wif.i_ms_to_ws_valid) slot.push_back(wif.i_ms_to_ws_bus);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic v, input ms_to_ws_t b);
    wif.i_ms_to_ws_valid = v;
    wif.i_ms_to_ws_bus   = b;
  endtask

  initial begin
    rst_n = 1'b0;
    wif.i_rf_busy = 1'b0;
    wif.i_flush = 1'b0;
    wif.i_cnt_wen = 1'b0;
    wif.i_cnt_wdata = '0;
    drv(1'b1, mk(1, 5'd5, 64'hAA, 0, 12'h0, 64'h0, 64'h80));
    step();
    mon_en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst_allowin", wif.o_ws_allowin, 1'b1);
      chk("rst_rf_bus", wif.o_to_rf_bus, '0);
      chk("rst_fwd", wif.o_ws_fwd_bus, '0);
      chk("rst_retire", {wif.o_retire_valid, wif.o_retire_pc}, '0);
      chk("rst_cnt", wif.o_retire_cnt, 64'd0);
      if (i == 0) step();
    end
    rst_n = 1'b1;
    drv(1'b0, '0);
    step();
    drv(1'b1, mk(1, 5'd5, 64'h11, 0, 12'h0, 64'h0, 64'h100));
    step();
    @(negedge clk);
    chk("stream_x5", wif.o_to_rf_bus, {1'b1, 5'd5, 64'h11, 1'b0, 12'h0, 64'h0});
    chk("stream_pc", wif.o_retire_pc, 64'h100);
    drv(1'b1, mk(1, 5'd6, 64'h22, 0, 12'h0, 64'h0, 64'h104));
    step();
    @(negedge clk);
    chk("stream_x6", wif.o_to_rf_bus, {1'b1, 5'd6, 64'h22, 1'b0, 12'h0, 64'h0});
    drv(1'b1, mk(1, 5'd7, 64'h33, 0, 12'h0, 64'h0, 64'h108));
    step();
    @(negedge clk);
    chk("stream_x7", wif.o_to_rf_bus, {1'b1, 5'd7, 64'h33, 1'b0, 12'h0, 64'h0});
    drv(1'b0, '0);
    step();
    @(negedge clk);
    chk("stream_cnt", wif.o_retire_cnt, 64'd3);
    drv(1'b1, mk(1, 5'd8, 64'h44, 0, 12'h0, 64'h0, 64'h200));
    step();
    drv(1'b1, mk(1, 5'd9, 64'h55, 0, 12'h0, 64'h0, 64'h204));
    wif.i_rf_busy = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("bp_allowin", wif.o_ws_allowin, 1'b0);
      chk("bp_rf_bus", wif.o_to_rf_bus, '0);
      chk("bp_fwd", wif.o_ws_fwd_bus, {1'b1, 5'd8, 64'h44});
      if (i == 0) step();
    end
    step();
    wif.i_rf_busy = 1'b0;
    @(negedge clk);
    chk("bp_release", wif.o_to_rf_bus, {1'b1, 5'd8, 64'h44, 1'b0, 12'h0, 64'h0});
    step();
    drv(1'b1, mk(1, 5'd0, 64'h99, 1, 12'h300, 64'h77, 64'h300));
    @(negedge clk);
    chk("bp_next_x9", wif.o_to_rf_bus, {1'b1, 5'd9, 64'h55, 1'b0, 12'h0, 64'h0});
    step();
    drv(1'b0, '0);
    @(negedge clk);
    chk("x0_rf_bus", wif.o_to_rf_bus, {1'b0, 5'd0, 64'h99, 1'b1, 12'h300, 64'h77});
    chk("x0_fwd_valid", wif.o_ws_fwd_bus[WS_FWD_BUS_WD-1], 1'b0);
    chk("x0_retire", wif.o_retire_valid, 1'b1);
    step();
    @(negedge clk);
    chk("x0_cnt", wif.o_retire_cnt, 64'd6);
    wif.i_cnt_wen = 1'b1;
    wif.i_cnt_wdata = '1;
    drv(1'b1, mk(1, 5'd10, 64'h66, 0, 12'h0, 64'h0, 64'h400));
    step();
    wif.i_cnt_wen = 1'b0;
    drv(1'b0, '0);
    @(negedge clk);
    chk("cnt_max", wif.o_retire_cnt, 64'hFFFF_FFFF_FFFF_FFFF);
    step();
    @(negedge clk);
    chk("cnt_wrap", wif.o_retire_cnt, 64'd0);
    drv(1'b1, mk(1, 5'd11, 64'h67, 0, 12'h0, 64'h0, 64'h404));
    step();
    drv(1'b0, '0);
    wif.i_cnt_wen = 1'b1;
    wif.i_cnt_wdata = 64'd100;
    @(negedge clk);
    chk("cnt_wr_retire", wif.o_retire_valid, 1'b1);
    step();
    wif.i_cnt_wen = 1'b0;
    @(negedge clk);
    chk("cnt_wr_prio", wif.o_retire_cnt, 64'd100);
    drv(1'b1, mk(1, 5'd12, 64'h88, 1, 12'h341, 64'h5, 64'h500));
    step();
    drv(1'b1, mk(1, 5'd13, 64'h89, 0, 12'h0, 64'h0, 64'h504));
    wif.i_flush = 1'b1;
    @(negedge clk);
    chk("fl_rf_bus", wif.o_to_rf_bus, '0);
    chk("fl_retire", wif.o_retire_valid, 1'b0);
    chk("fl_allowin", wif.o_ws_allowin, 1'b1);
    step();
    wif.i_flush = 1'b0;
    drv(1'b0, '0);
    @(negedge clk);
    chk("fl_empty", {wif.o_retire_valid, wif.o_ws_fwd_bus[WS_FWD_BUS_WD-1], wif.o_retire_pc}, '0);
    chk("fl_cnt", wif.o_retire_cnt, 64'd100);
    drv(1'b1, mk(1, 5'd14, 64'h90, 0, 12'h0, 64'h0, 64'h600));
    step();
    drv(1'b0, '0);
    wif.i_rf_busy = 1'b1;
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    wif.i_rf_busy = 1'b0;
    @(negedge clk);
    chk("rst_stall_rf", wif.o_to_rf_bus, '0);
    chk("rst_stall_ret", wif.o_retire_valid, 1'b0);
    chk("rst_stall_cnt", wif.o_retire_cnt, 64'd0);
    step();
    step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
